// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: data width, FSM state
// encoding and transaction owner encoding.
package mem_arbiter_pkg;

  localparam int D_XLEN = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// mem_arb_pick: priority decision between fetch and data requesters.
// Data wins on contention unless MAX_D_STREAK consecutive data grants
// have already been made while fetch was waiting.
//   clk, reset   : clock, asynchronous active-low reset
//   i_req, d_req : current fetch / data requests
//   pick_en      : high in the arbitration (IDLE) cycle; streak updates
//                  only when a selection is actually made
//   pick_d       : 1 = select data, 0 = select fetch (valid when any req)
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic d_req,
  input  logic pick_en,
  output logic pick_d
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] LIMIT = SW'(MAX_D_STREAK);

  logic [SW-1:0] streak;

  always_comb begin
    pick_d = d_req && (!i_req || (streak < LIMIT));
  end

  // Streak counts only data wins that made a waiting fetch wait longer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak <= '0;
    end else if (pick_en && (i_req || d_req)) begin
      if (pick_d && i_req) begin
        if (streak != LIMIT) streak <= streak + 1'b1;
      end else begin
        streak <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (i_*)
// and load/store (d_*). One transaction in flight; IDLE picks an owner,
// REQ forwards the owner's fields until m_gnt, RESP waits for m_rvalid
// and routes the response back.
//   clk, reset          : clock, asynchronous active-low reset
//   i_req/i_addr        : fetch request;  i_gnt/i_rvalid/i_rdata back
//   d_req/d_we/d_be/
//   d_addr/d_wdata      : data request;   d_gnt/d_rvalid/d_rdata back
//   m_req/m_we/m_be/
//   m_addr/m_wdata      : memory request; m_gnt/m_rvalid/m_rdata back
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [D_XLEN-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [D_XLEN-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [D_XLEN-1:0] d_addr,
  input  logic [D_XLEN-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [D_XLEN-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [D_XLEN-1:0] m_addr,
  output logic [D_XLEN-1:0] m_wdata,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [D_XLEN-1:0] m_rdata
);

  arb_state_t state, state_d;
  arb_owner_t owner, owner_d;
  logic       pick_en;
  logic       pick_d;

  mem_arb_pick #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_pick (
    .clk    (clk),
    .reset  (reset),
    .i_req  (i_req),
    .d_req  (d_req),
    .pick_en(pick_en),
    .pick_d (pick_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ARB_IDLE;
      owner <= OWN_I;
    end else begin
      state <= state_d;
      owner <= owner_d;
    end
  end

  // Memory-side fields are gated by REQ so the port reads 0 when idle,
  // even though the reset owner (fetch) would otherwise drive m_be=F.
  always_comb begin
    state_d  = state;
    owner_d  = owner;
    pick_en  = 1'b0;
    m_req    = 1'b0;
    m_we     = 1'b0;
    m_be     = '0;
    m_addr   = '0;
    m_wdata  = '0;
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    i_rdata  = '0;
    d_rdata  = '0;
    case (state)
      ARB_IDLE: begin
        pick_en = 1'b1;
        if (i_req || d_req) begin
          owner_d = pick_d ? OWN_D : OWN_I;
          state_d = ARB_REQ;
        end
      end
      ARB_REQ: begin
        m_req = 1'b1;
        if (owner == OWN_D) begin
          m_we    = d_we;
          m_be    = d_be;
          m_addr  = d_addr;
          m_wdata = d_wdata;
          d_gnt   = m_gnt;
        end else begin
          m_be    = 4'hF;
          m_addr  = i_addr;
          i_gnt   = m_gnt;
        end
        if (m_gnt) state_d = ARB_RESP;
      end
      ARB_RESP: begin
        if (m_rvalid) begin
          if (owner == OWN_D) begin
            d_rvalid = 1'b1;
            d_rdata  = m_rdata;
          end else begin
            i_rvalid = 1'b1;
            i_rdata  = m_rdata;
          end
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;
  logic        m_gnt, m_rvalid;
  logic [31:0] m_rdata;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(
    .MAX_D_STREAK(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_gnt   (i_gnt),
    .i_rvalid(i_rvalid),
    .i_rdata (i_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_be    (d_be),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_gnt   (d_gnt),
    .d_rvalid(d_rvalid),
    .d_rdata (d_rdata),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_be    (m_be),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_gnt   (m_gnt),
    .m_rvalid(m_rvalid),
    .m_rdata (m_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_chk(input string tag);
    check({tag, "_ctl"}, 32'({m_req, m_we, m_be, i_gnt, d_gnt, i_rvalid, d_rvalid}), 32'h0);
    check({tag, "_maddr"}, m_addr, 32'h0);
    check({tag, "_mwdata"}, m_wdata, 32'h0);
    check({tag, "_irdata"}, i_rdata, 32'h0);
    check({tag, "_drdata"}, d_rdata, 32'h0);
  endtask

  // Starts in an IDLE cycle with requests already driven; returns in the
  // following IDLE cycle. gw = cycles before m_gnt, rw = cycles from
  // m_gnt to m_rvalid. keep=0 drops the winner's request after its grant.
  task automatic serve(input logic exp_d, input logic [31:0] addr, input logic we,
                       input logic [3:0] be, input logic [31:0] wd, input int gw,
                       input int rw, input logic [31:0] rd, input logic keep);
    @(negedge clk);
    check("idle_mreq", 32'(m_req), 32'h0);
    tick();
    for (int k = 0; k < gw; k++) begin
      m_gnt = 1'b0;
      @(negedge clk);
      check("wait_mreq", 32'(m_req), 32'h1);
      check("wait_addr", m_addr, addr);
      check("wait_gnt", 32'({i_gnt, d_gnt}), 32'h0);
      tick();
    end
    m_gnt = 1'b1;
    @(negedge clk);
    check("req_mreq", 32'(m_req), 32'h1);
    check("req_addr", m_addr, addr);
    check("req_we", 32'(m_we), 32'(we));
    check("req_be", 32'(m_be), 32'(be));
    check("req_wdata", m_wdata, wd);
    check("i_gnt", 32'(i_gnt), 32'(!exp_d));
    check("d_gnt", 32'(d_gnt), 32'(exp_d));
    tick();
    m_gnt = 1'b0;
    if (!keep) begin
      if (exp_d) d_req = 1'b0;
      else       i_req = 1'b0;
    end
    for (int k = 1; k < rw; k++) begin
      @(negedge clk);
      check("resp_wait", 32'({m_req, i_gnt, d_gnt, i_rvalid, d_rvalid}), 32'h0);
      tick();
    end
    m_rvalid = 1'b1;
    m_rdata  = rd;
    @(negedge clk);
    check("i_rvalid", 32'(i_rvalid), 32'(!exp_d));
    check("d_rvalid", 32'(d_rvalid), 32'(exp_d));
    check("i_rdata", i_rdata, exp_d ? 32'h0 : rd);
    check("d_rdata", d_rdata, exp_d ? rd : 32'h0);
    check("resp_mreq", 32'(m_req), 32'h0);
    tick();
    m_rvalid = 1'b0;
    m_rdata  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset with busy inputs: outputs must still read 0.
    reset = 1'b0;
    i_req = 1'b1; i_addr = 32'h111;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h222; d_wdata = 32'h333;
    m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hFFFFFFFF;
    #2;
    rst_chk("rst0");
    tick();
    rst_chk("rst1");
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Fetch alone, zero-wait memory.
    i_req = 1'b1; i_addr = 32'h400;
    serve(1'b0, 32'h400, 1'b0, 4'hF, 32'h0, 0, 1, 32'h00000013, 1'b0);

    // Contention: data first, then fetch.
    i_req = 1'b1; i_addr = 32'h500;
    d_req = 1'b1; d_addr = 32'h3FC; d_we = 1'b1; d_be = 4'h3; d_wdata = 32'hDEADBEEF;
    serve(1'b1, 32'h3FC, 1'b1, 4'h3, 32'hDEADBEEF, 0, 1, 32'h0, 1'b0);
    serve(1'b0, 32'h500, 1'b0, 4'hF, 32'h0, 0, 1, 32'h00000093, 1'b0);

    // Starvation guard: D,D,D,D,I repeated.
    i_req = 1'b1; i_addr = 32'h600;
    d_req = 1'b1; d_addr = 32'h700; d_we = 1'b0; d_be = 4'hF; d_wdata = 32'h0;
    for (int n = 0; n < 10; n++) begin
      if ((n % 5) != 4)
        serve(1'b1, 32'h700, 1'b0, 4'hF, 32'h0, 0, 1, 32'h1000 + 32'(n), 1'b1);
      else
        serve(1'b0, 32'h600, 1'b0, 4'hF, 32'h0, 0, 1, 32'h2000 + 32'(n), 1'b1);
    end
    i_req = 1'b0; d_req = 1'b0;

    // Slow memory: grant after 3 cycles, response 5 cycles after grant.
    d_req = 1'b1; d_addr = 32'h800; d_we = 1'b0; d_be = 4'hC; d_wdata = 32'h12345678;
    serve(1'b1, 32'h800, 1'b0, 4'hC, 32'h12345678, 3, 5, 32'hCAFEF00D, 1'b0);

    // Reset while in RESP, then a late response after release.
    d_req = 1'b1; d_addr = 32'h900; d_we = 1'b0; d_be = 4'hF; d_wdata = 32'h0;
    @(negedge clk);
    tick();
    m_gnt = 1'b1;
    @(negedge clk);
    check("mt_dgnt", 32'(d_gnt), 32'h1);
    tick();
    m_gnt = 1'b0; d_req = 1'b0;
    #1;
    reset = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    rst_chk("mt_rst0");
    tick();
    rst_chk("mt_rst1");
    @(negedge clk);
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("late_rvalid", 32'({i_rvalid, d_rvalid}), 32'h0);
    check("late_drdata", d_rdata, 32'h0);
    check("late_mreq", 32'(m_req), 32'h0);
    tick();
    m_rvalid = 1'b0; m_rdata = '0;

    // Idle with stray memory pulses.
    for (int n = 0; n < 10; n++) begin
      m_gnt    = (n % 2) == 1;
      m_rvalid = (n % 3) == 0;
      m_rdata  = 32'hA5A5A5A5;
      @(negedge clk);
      check("idle_out", 32'({m_req, i_gnt, d_gnt, i_rvalid, d_rvalid}), 32'h0);
      tick();
    end
    m_gnt = 1'b0; m_rvalid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
